uart_sample_framer: RTL and testbench
=====================================

# uart_sample_framer

Sits directly downstream of the UART receiver. Consumes its byte strobe, pairs consecutive bytes into little-endian 16-bit samples, and fills a frame buffer of `N_SAMPLES` entries. When the buffer is full it presents the frame to the FFT stage through a read port and frame-ready/ack handshake, then waits for the FFT stage to release it.

## Interface
- `N_SAMPLES`, default 256: samples per frame; power of two, ≥ 2.
- `ADDR_W`, default 8: log2(`N_SAMPLES`).
- `TIMEOUT_TICKS`, default 4096: max cycles between low and high byte of one sample. Used only with `FRAMER_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_rx_flag` in 1: receiver byte strobe; idles high, low for exactly one cycle per byte.
- `i_rx_byte` in 16: receiver byte; only [7:0] used, stable when `i_rx_flag` is low.
- `o_frame_ready` out 1: high while a complete frame is held.
- `i_frame_ack` in 1: one-cycle pulse from the FFT stage releasing the frame.
- `i_rd_addr` in `ADDR_W`: sample read address.
- `o_rd_data` out 16: sample at `i_rd_addr`, registered.
- `o_overrun` out 1: sticky; a byte arrived while the frame was full.
- `o_sync_err` out 1: one-cycle pulse on inter-byte timeout.
- `o_fill_count` out `ADDR_W`+1: samples written in the current frame.

## Operation
- Strobe detection: a byte is accepted on the first cycle `i_rx_flag` is low after being high. Detection uses a previous-value register that resets to 1. Consecutive low cycles count as one byte.
- States:
  - FILL_LO: an accepted byte is latched as the low byte, then go to FILL_HI.
  - FILL_HI: an accepted byte writes {byte, low} to RAM[`wr_ptr`]. `wr_ptr` and `o_fill_count` increment. If `wr_ptr` was `N_SAMPLES`-1, go to FULL; otherwise go to FILL_LO.
  - FULL: `o_frame_ready` = 1. Accepted bytes are discarded and set `o_overrun`. `i_frame_ack` clears `wr_ptr`, `o_fill_count`, and `o_overrun`, then goes to FILL_LO.
- `i_frame_ack` outside FULL: ignored.
- Ack and byte in the same FULL cycle: ack takes effect and the byte is discarded. `o_overrun` ends at 0 because the ack clear wins.
- Read port: `o_rd_data` = RAM[`i_rd_addr`] one cycle later, in any state. Contents are meaningful only while `o_frame_ready`.
- `wr_ptr` is `ADDR_W` bits and wraps to 0 naturally at the end of a frame. `o_fill_count` reaches `N_SAMPLES` exactly in FULL.
- Reset mid-frame: the partial frame is abandoned and the low byte is discarded. RAM contents are not cleared.
- Reset values: `o_frame_ready`=0, `o_rd_data`=0, `o_overrun`=0, `o_sync_err`=0, `o_fill_count`=0. State is FILL_LO, `wr_ptr`=0.

## Timing
- Byte accept → low-byte latch: registered on the accept cycle edge.
- High-byte accept → RAM write on the same edge. `o_fill_count` updates at that edge.
- Last high byte accepted in cycle t → `o_frame_ready` high from t+1.
- `i_frame_ack` in cycle t → `o_frame_ready` low from t+1. A byte accepted in t+1 is the low byte of sample 0.
- Read latency: 1 cycle, fully pipelined, one address per cycle.

## Configuration
- `FRAMER_TIMEOUT_EN` defined:
  - In FILL_HI a counter starts at 0 on entry and increments each cycle.
  - When it reaches `TIMEOUT_TICKS`-1 without a byte, the low byte is discarded, `o_sync_err` pulses for one cycle, and the state returns to FILL_LO.
  - A byte accepted on that same cycle is taken as a new low byte, so the state stays FILL_HI with the counter reset.
- `FRAMER_TIMEOUT_EN` undefined: no counter. `o_sync_err` is tied 0. FILL_HI waits indefinitely.

## Structure
- Shared package `framer_pkg` holds:
  - `SAMPLE_W` = 16;
  - state encodings `ST_FILL_LO`, `ST_FILL_HI`, `ST_FULL`;
  - a default `TIMEOUT_TICKS` constant.
- One sub-module: `sample_ram`, a simple dual-port RAM with one write port and one synchronous-read port, depth `N_SAMPLES`, width `SAMPLE_W`, and no reset on the array.
- Strobe detection, FSM, and counters live in the top.

## Test plan
- Reset, then 2·`N_SAMPLES` bytes (0x00,0x01,0x02,…) → `o_frame_ready` rises one cycle after the last byte. Reading address k gives {2k+1, 2k}, e.g. addr 3 → 0x0706.
- Frame full, then 3 more bytes → `o_overrun`=1, RAM unchanged. Ack → `o_overrun`=0, `o_frame_ready`=0, `o_fill_count`=0.
- Ack and a byte strobe in the same cycle while FULL → byte dropped, `o_overrun`=0. The next byte pair is written to addr 0.
- With `FRAMER_TIMEOUT_EN` and `TIMEOUT_TICKS`=16: byte 0xAA, 20 idle cycles, then 0x34, 0x12 → one `o_sync_err` pulse, and RAM[0]=0x1234.
- `i_rx_flag` held low for 5 cycles with byte 0x55 → counted as one byte only (`o_fill_count` unchanged, state FILL_HI).
- `i_rst_n` asserted asynchronously after 10 bytes → all outputs 0 immediately. A fresh full frame afterwards starts at addr 0.

Source files
------------

// File: rtl/framer_pkg.sv
// Shared constants and FSM state encoding for the UART sample framer.
package framer_pkg;

    localparam int unsigned SAMPLE_W              = 16;
    localparam int unsigned DEFAULT_TIMEOUT_TICKS = 4096;

    typedef enum logic [1:0] {
        ST_FILL_LO = 2'd0,
        ST_FILL_HI = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous-read port.
// Only the read data register is reset; the array itself is not.
module sample_ram
    import framer_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [SAMPLE_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [SAMPLE_W-1:0] o_rd_data
);

    logic [SAMPLE_W-1:0] r_mem [DEPTH];
    logic [SAMPLE_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_sample_framer.sv
// Pairs UART bytes into little-endian 16-bit samples and buffers one frame for the FFT stage.
// Optional inter-byte timeout enabled by defining FRAMER_TIMEOUT_EN.
module uart_sample_framer
    import framer_pkg::*;
#(
    parameter int unsigned N_SAMPLES     = 256,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx_flag,
    input  logic [15:0]         i_rx_byte,
    output logic                o_frame_ready,
    input  logic                i_frame_ack,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [SAMPLE_W-1:0] o_rd_data,
    output logic                o_overrun,
    output logic                o_sync_err,
    output logic [ADDR_W:0]     o_fill_count
);

    state_e            r_state;
    state_e            w_state_next;
    logic              r_rx_flag_prev;
    logic              w_accept;
    logic [7:0]        r_low_byte;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_fill_count;
    logic              r_overrun;
    logic              w_last_sample;
    logic              w_timeout;
    logic              w_latch_low;
    logic              w_wr_en;
    logic              w_ack;
    logic              w_overrun_set;
    logic              w_unused;

    // Falling edge of the idle-high strobe; a held-low strobe counts once.
    assign w_accept      = r_rx_flag_prev & ~i_rx_flag;
    assign w_last_sample = (r_wr_ptr == ADDR_W'(N_SAMPLES - 1));
    assign w_unused      = ^{i_rx_byte[15:8], 1'(TIMEOUT_TICKS)};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_FILL_LO;
            r_rx_flag_prev <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            r_rx_flag_prev <= i_rx_flag;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_FILL_LO: begin
                if (w_accept) w_state_next = ST_FILL_HI;
            end
            ST_FILL_HI: begin
                if (w_timeout) begin
                    w_state_next = w_accept ? ST_FILL_HI : ST_FILL_LO;
                end else if (w_accept) begin
                    w_state_next = w_last_sample ? ST_FULL : ST_FILL_LO;
                end
            end
            ST_FULL: begin
                if (i_frame_ack) w_state_next = ST_FILL_LO;
            end
            default: w_state_next = ST_FILL_LO;
        endcase
    end

    always_comb begin
        w_latch_low   = 1'b0;
        w_wr_en       = 1'b0;
        w_ack         = 1'b0;
        w_overrun_set = 1'b0;
        o_frame_ready = 1'b0;
        unique case (r_state)
            ST_FILL_LO: w_latch_low = w_accept;
            ST_FILL_HI: begin
                // On a timeout cycle the incoming byte restarts the pair as a new low byte.
                w_latch_low = w_accept & w_timeout;
                w_wr_en     = w_accept & ~w_timeout;
            end
            ST_FULL: begin
                o_frame_ready = 1'b1;
                w_ack         = i_frame_ack;
                w_overrun_set = w_accept & ~i_frame_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_low_byte   <= '0;
            r_wr_ptr     <= '0;
            r_fill_count <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_latch_low) begin
                r_low_byte <= i_rx_byte[7:0];
            end
            if (w_wr_en) begin
                r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
                r_fill_count <= r_fill_count + (ADDR_W + 1)'(1);
            end
            if (w_ack) begin
                r_wr_ptr     <= '0;
                r_fill_count <= '0;
                r_overrun    <= 1'b0;
            end else if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef FRAMER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS) + 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_sync_err;

    assign w_timeout = (r_state == ST_FILL_HI) && (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt   <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_timeout;
            if ((r_state == ST_FILL_HI) && (w_state_next == ST_FILL_HI) && !w_timeout) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign o_sync_err = r_sync_err;
`else
    assign w_timeout  = 1'b0;
    assign o_sync_err = 1'b0;
`endif

    assign o_overrun    = r_overrun;
    assign o_fill_count = r_fill_count;

    sample_ram #(
        .DEPTH  (N_SAMPLES),
        .ADDR_W (ADDR_W)
    ) u_sample_ram (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({i_rx_byte[7:0], r_low_byte}),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

endmodule

// File: tb/tb_uart_sample_framer.sv
// Scoreboard bench for uart_sample_framer: a byte-list model predicts frames, a monitor reads them back.
module tb_uart_sample_framer;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned TT = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          rx_flag = 1'b1;
    logic [15:0]   rx_byte = '0;
    logic          ack     = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          frame_ready;
    logic [15:0]   rd_data;
    logic          overrun;
    logic          sync_err;
    logic [AW:0]   fill_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  m_bytes[$];
    bit          m_full    = 0;
    bit          m_overrun = 0;
    logic [15:0] m_frame [N];
    int          frames_read = 0;
    int          rd_req      = 0;
    int          rd_srv      = 0;

    uart_sample_framer #(
        .N_SAMPLES     (N),
        .ADDR_W        (AW),
        .TIMEOUT_TICKS (TT)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_flag     (rx_flag),
        .i_rx_byte     (rx_byte),
        .o_frame_ready (frame_ready),
        .i_frame_ack   (ack),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_overrun     (overrun),
        .o_sync_err    (sync_err),
        .o_fill_count  (fill_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the accepted bytes of the current frame, paired once the frame is complete.
    function automatic void model_byte(input logic [7:0] b);
        if (m_full) begin
            m_overrun = 1;
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 2 * N) begin
                for (int k = 0; k < N; k++) begin
                    m_frame[k] = {m_bytes[2*k+1], m_bytes[2*k]};
                    exp_q.push_back(m_frame[k]);
                end
                m_bytes.delete();
                m_full = 1;
            end
        end
    endfunction

    function automatic void model_ack();
        if (m_full) begin
            m_full    = 0;
            m_overrun = 0;
        end
    endfunction

    function automatic void model_reset();
        m_bytes.delete();
        m_full    = 0;
        m_overrun = 0;
    endfunction

    function automatic int model_fill();
        return m_full ? N : m_bytes.size() / 2;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold = 1);
        @(negedge clk);
        rx_flag = 1'b0;
        rx_byte = {8'($urandom), b};
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        rx_flag = 1'b1;
        rx_byte = 16'($urandom);
        model_byte(b);
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(b);
    endtask

    task automatic send_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        model_ack();
    endtask

    // Ack and strobe in the same cycle: the byte is dropped.
    task automatic send_ack_with_byte(input logic [7:0] b);
        @(negedge clk);
        ack     = 1'b1;
        rx_flag = 1'b0;
        rx_byte = {8'h00, b};
        @(negedge clk);
        ack     = 1'b0;
        rx_flag = 1'b1;
        model_ack();
    endtask

    task automatic wait_reads(input int target, input string name);
        int i = 0;
        while (frames_read < target && i < 400) begin
            @(negedge clk);
            i++;
        end
        check(name, frames_read, target);
    endtask

    task automatic reread();
        for (int k = 0; k < N; k++) exp_q.push_back(m_frame[k]);
        rd_req++;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " frame_ready"}, frame_ready, m_full);
        check({tag, " overrun"}, overrun, m_overrun);
        check({tag, " fill_count"}, fill_count, model_fill());
    endtask

    // Monitor: reads the whole frame back, one address per cycle, whenever a frame is presented.
    initial begin
        logic prev_rdy;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && ((frame_ready && !prev_rdy) || rd_req != rd_srv)) begin
                if (rd_req != rd_srv) rd_srv++;
                rd_addr = '0;
                for (int k = 1; k <= N; k++) begin
                    @(negedge clk);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rd_data addr %0d: got 0x%0h, no expected sample", k - 1,
                                 rd_data);
                    end else begin
                        check($sformatf("rd_data addr %0d", k - 1), rd_data, exp_q.pop_front());
                    end
                    if (k < N) rd_addr = AW'(k);
                end
                frames_read++;
            end
            prev_rdy = frame_ready;
        end
    end

    initial begin
        int pulses;
        int exp_pulses;

        repeat (3) @(negedge clk);
        check("reset rd_data", rd_data, 16'h0000);
        check("reset sync_err", sync_err, 1'b0);
        check_outputs("reset");
        rst_n = 1'b1;

        // Ascending frame: address k holds {2k+1, 2k}.
        for (int i = 0; i < 2 * N - 1; i++) send_byte(8'(i));
        check_outputs("before last byte");
        send_byte(8'(2 * N - 1));
        check("ready after last byte", frame_ready, 1'b1);
        check_outputs("frame 1 full");
        wait_reads(1, "frame 1 readback");

        repeat (3) send_byte(8'($urandom));
        check_outputs("after overrun");
        reread();
        wait_reads(2, "readback after overrun");
        send_ack();
        check_outputs("after ack");

        for (int i = 0; i < 2 * N; i++) send_gap(8'($urandom));
        wait_reads(3, "random frame readback");
        check_outputs("random frame full");
        send_ack_with_byte(8'hEE);
        check_outputs("ack with byte");

        send_byte(8'h55, 5);
        check_outputs("held-low strobe");
        send_byte(8'h66);
        check_outputs("pair after held strobe");

        send_byte(8'hAA);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (sync_err) pulses++;
        end
`ifdef FRAMER_TIMEOUT_EN
        void'(m_bytes.pop_back());
        exp_pulses = 1;
`else
        exp_pulses = 0;
`endif
        check("sync_err pulses", pulses, exp_pulses);
        send_byte(8'h34);
        send_byte(8'h12);
        check_outputs("after timeout pair");
        while (!m_full) send_gap(8'($urandom));
        wait_reads(4, "timeout frame readback");
        send_ack();

        repeat (10) send_byte(8'($urandom));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("async reset rd_data", rd_data, 16'h0000);
        check("async reset sync_err", sync_err, 1'b0);
        check_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * N; i++) send_gap(8'($urandom));
        wait_reads(5, "post-reset frame readback");
        check_outputs("post-reset frame full");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
